// File: rtl/mem_bus_arbiter.sv
// Two-master to one-slave pipelined Wishbone arbiter.
// Master 0 is instruction fetch and master 1 is load/store. The bus is granted
// for whole cyc-framed cycles, and simultaneous requests are resolved round-robin.
// Handshake: a transfer is accepted on a cycle where wb_stb_o=1 and wb_stall_i=0.
// A master may only advance when it sees stb=1 together with stall_o=0.
// Each accepted transfer is later answered by exactly one wb_ack_i.
// The slave port is a combinational mux of the granted master. The state,
// last-granted and outstanding-count registers set what that mux selects.
module mem_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic        m0_ack_o,
  output logic        m0_stall_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic        m1_ack_o,
  output logic        m1_stall_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] outst_q, outst_d;

  logic        granted;
  logic        sel1;
  logic        limit;
  logic        g_cyc;
  logic        g_stb;
  logic        other_cyc;
  logic        accept;
  logic        dec;

  // Select the granted master's request signals
  always_comb begin
    granted   = (state_q == GRANT0) || (state_q == GRANT1);
    sel1      = (state_q == GRANT1);
    g_cyc     = sel1 ? m1_cyc_i : m0_cyc_i;
    g_stb     = sel1 ? m1_stb_i : m0_stb_i;
    other_cyc = sel1 ? m0_cyc_i : m1_cyc_i;
    limit     = granted && (outst_q == MAX_CNT);
  end

  // Route the granted master to the slave; park everything else
  always_comb begin
    wb_adr_o   = '0;
    wb_dat_o   = '0;
    wb_we_o    = 1'b0;
    wb_sel_o   = '0;
    wb_stb_o   = 1'b0;
    wb_cyc_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_stall_o = 1'b1;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_dat_o   = '0;
    m1_dat_o   = '0;
    if (granted) begin
      wb_adr_o = sel1 ? m1_adr_i : m0_adr_i;
      wb_dat_o = sel1 ? m1_dat_i : m0_dat_i;
      wb_we_o  = sel1 ? m1_we_i  : m0_we_i;
      wb_sel_o = sel1 ? m1_sel_i : m0_sel_i;
      wb_cyc_o = g_cyc;
      wb_stb_o = g_stb & ~limit;
      if (sel1) begin
        m1_stall_o = wb_stall_i | limit;
        m1_ack_o   = wb_ack_i;
        m1_dat_o   = wb_dat_i;
      end else begin
        m0_stall_o = wb_stall_i | limit;
        m0_ack_o   = wb_ack_i;
        m0_dat_o   = wb_dat_i;
      end
    end
  end

  // Next grant, round-robin pointer and in-flight count
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    outst_d = outst_q;
    accept  = wb_stb_o & ~wb_stall_i;
    // An ack with nothing counted is still forwarded but must not wrap the count.
    dec     = wb_ack_i & (outst_q != '0);
    case (state_q)
      IDLE: begin
        // Late acks from an aborted cycle land here and are simply dropped.
        outst_d = '0;
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GRANT0 : GRANT1;
        else if (m0_cyc_i)        state_d = GRANT0;
        else if (m1_cyc_i)        state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (!g_cyc) begin
          // Release: the cycle ends now and anything still in flight is aborted.
          last_d  = sel1;
          outst_d = '0;
          if (other_cyc) state_d = sel1 ? GRANT0 : GRANT1;
          else           state_d = IDLE;
        end else begin
          outst_d = outst_q + {{(CNT_W-1){1'b0}}, accept}
                            - {{(CNT_W-1){1'b0}}, dec};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      outst_q <= outst_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed vector table, hand-written reset
// sequence, and randomized traffic against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int MAXO = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT connections ----------------
  logic [31:0] m_adr [2];
  logic [31:0] m_wdat[2];
  logic        m_we  [2];
  logic [3:0]  m_sel [2];
  logic        m_stb [2];
  logic        m_cyc [2];
  logic [31:0] wb_rdat;
  logic        wb_ack;
  logic        wb_stall;

  wire [31:0] m0_dat_o, m1_dat_o, wb_adr_o, wb_dat_o;
  wire        m0_ack_o, m1_ack_o, m0_stall_o, m1_stall_o;
  wire        wb_we_o, wb_stb_o, wb_cyc_o;
  wire [3:0]  wb_sel_o;

  logic [31:0] o_dat  [2];
  logic        o_ack  [2];
  logic        o_stall[2];
  assign o_dat[0]   = m0_dat_o;
  assign o_dat[1]   = m1_dat_o;
  assign o_ack[0]   = m0_ack_o;
  assign o_ack[1]   = m1_ack_o;
  assign o_stall[0] = m0_stall_o;
  assign o_stall[1] = m1_stall_o;

  mem_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_wdat[0]), .m0_dat_o(m0_dat_o),
    .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]), .m0_stb_i(m_stb[0]),
    .m0_cyc_i(m_cyc[0]), .m0_ack_o(m0_ack_o), .m0_stall_o(m0_stall_o),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_wdat[1]), .m1_dat_o(m1_dat_o),
    .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]), .m1_stb_i(m_stb[1]),
    .m1_cyc_i(m_cyc[1]), .m1_ack_o(m1_ack_o), .m1_stall_o(m1_stall_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_rdat),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack), .wb_stall_i(wb_stall)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: -1 = bus free, else index of the master holding the bus.
  // inflight: accepted transfers not yet acknowledged in the current tenure.
  // last: master that most recently finished a tenure (loses the next tie).
  int owner;
  int inflight;
  int last;

  task automatic model_reset();
    owner    = -1;
    inflight = 0;
    last     = 1;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_update();
    int g;
    int acc;
    int dec;
    if (owner < 0) begin
      if (m_cyc[0] && m_cyc[1]) owner = (last == 0) ? 1 : 0;
      else if (m_cyc[0])        owner = 0;
      else if (m_cyc[1])        owner = 1;
      inflight = 0;
    end else begin
      g = owner;
      if (!m_cyc[g]) begin
        last     = g;
        inflight = 0;
        owner    = m_cyc[1-g] ? (1 - g) : -1;
      end else begin
        acc = (m_stb[g] && inflight < MAXO && !wb_stall) ? 1 : 0;
        dec = (wb_ack && inflight > 0) ? 1 : 0;
        inflight = inflight + acc - dec;
      end
    end
  endtask

  // Compare every DUT output with what the model says right now.
  task automatic model_check();
    logic        e_cyc, e_stb, e_we, lim;
    logic [31:0] e_adr, e_wd;
    logic [3:0]  e_sel;
    logic        e_stall[2];
    logic        e_ack[2];
    logic [31:0] e_dat[2];
    e_cyc = 0; e_stb = 0; e_we = 0; e_adr = 0; e_wd = 0; e_sel = 0;
    for (int k = 0; k < 2; k++) begin
      e_stall[k] = 1; e_ack[k] = 0; e_dat[k] = 0;
    end
    if (owner >= 0) begin
      lim   = (inflight == MAXO);
      e_cyc = m_cyc[owner];
      e_stb = m_stb[owner] && !lim;
      e_we  = m_we[owner];
      e_adr = m_adr[owner];
      e_wd  = m_wdat[owner];
      e_sel = m_sel[owner];
      e_stall[owner] = wb_stall || lim;
      e_ack[owner]   = wb_ack;
      e_dat[owner]   = wb_rdat;
    end
    chk("rnd wb_cyc", 32'(wb_cyc_o), 32'(e_cyc));
    chk("rnd wb_stb", 32'(wb_stb_o), 32'(e_stb));
    chk("rnd wb_we",  32'(wb_we_o),  32'(e_we));
    chk("rnd wb_adr", wb_adr_o, e_adr);
    chk("rnd wb_dat", wb_dat_o, e_wd);
    chk("rnd wb_sel", 32'(wb_sel_o), 32'(e_sel));
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rnd m%0d_stall", k), 32'(o_stall[k]), 32'(e_stall[k]));
      chk($sformatf("rnd m%0d_ack", k),   32'(o_ack[k]),   32'(e_ack[k]));
      chk($sformatf("rnd m%0d_dat", k),   o_dat[k],        e_dat[k]);
    end
  endtask

  // ---------------- driver tasks ----------------
  logic        got_cyc, got_stb;
  logic [31:0] got_adr;
  logic        got_stall[2];
  logic        got_ack[2];
  logic [31:0] got_dat[2];

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(input bit use_model);
    #1;
    if (use_model) model_check();
    got_cyc = wb_cyc_o;
    got_stb = wb_stb_o;
    got_adr = wb_adr_o;
    for (int k = 0; k < 2; k++) begin
      got_stall[k] = o_stall[k];
      got_ack[k]   = o_ack[k];
      got_dat[k]   = o_dat[k];
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      m_adr[k] = 0; m_stb[k] = 0; m_cyc[k] = 0;
    end
    m_wdat[0] = 32'h0A0A_0A0A; m_we[0] = 1'b0; m_sel[0] = 4'hF;
    m_wdat[1] = 32'hB0B0_B0B0; m_we[1] = 1'b1; m_sel[1] = 4'h3;
    wb_rdat = 0; wb_ack = 0; wb_stall = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst_before;
    logic        c0, s0;
    logic [31:0] a0;
    logic        c1, s1;
    logic [31:0] a1;
    logic        ack, stall;
    logic [31:0] rdat;
    logic        e_cyc, e_stb;
    logic [31:0] e_adr;
    logic        e_s0, e_a0;
    logic [31:0] e_d0;
    logic        e_s1, e_a1;
    logic [31:0] e_d1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic r, logic c0, logic s0, logic [31:0] a0, logic c1, logic s1, logic [31:0] a1,
    logic ack, logic stall, logic [31:0] rdat,
    logic ecyc, logic estb, logic [31:0] eadr,
    logic es0, logic ea0, logic [31:0] ed0, logic es1, logic ea1, logic [31:0] ed1);
    vec_t v;
    v.rst_before = r;
    v.c0 = c0; v.s0 = s0; v.a0 = a0; v.c1 = c1; v.s1 = s1; v.a1 = a1;
    v.ack = ack; v.stall = stall; v.rdat = rdat;
    v.e_cyc = ecyc; v.e_stb = estb; v.e_adr = eadr;
    v.e_s0 = es0; v.e_a0 = ea0; v.e_d0 = ed0;
    v.e_s1 = es1; v.e_a1 = ea1; v.e_d1 = ed1;
    return v;
  endfunction

  task automatic fill_table();
    // single fetch: IDLE, grant, ack with data, release, idle
    vecs.push_back(mk(1, 1,1,32'h1000, 0,0,0, 0,0,0,        0,0,0,        1,0,0,     1,0,0));
    vecs.push_back(mk(0, 1,1,32'h1000, 0,0,0, 0,0,0,        1,1,32'h1000, 0,0,0,     1,0,0));
    vecs.push_back(mk(0, 1,0,32'h1000, 0,0,0, 1,0,32'h13,   1,0,32'h1000, 0,1,32'h13, 1,0,0));
    vecs.push_back(mk(0, 0,0,0,        0,0,0, 0,0,0,        0,0,0,        0,0,0,     1,0,0));
    vecs.push_back(mk(0, 0,0,0,        0,0,0, 0,0,0,        0,0,0,        1,0,0,     1,0,0));
    // tie after reset -> master 0, handoff to master 1, abort, late ack dropped
    vecs.push_back(mk(1, 1,0,32'h1000, 1,0,32'h2000, 0,0,0, 0,0,0,        1,0,0, 1,0,0));
    vecs.push_back(mk(0, 1,0,32'h1000, 1,0,32'h2000, 0,0,0, 1,0,32'h1000, 0,0,0, 1,0,0));
    vecs.push_back(mk(0, 0,0,32'h1000, 1,0,32'h2000, 0,0,0, 0,0,32'h1000, 0,0,0, 1,0,0));
    vecs.push_back(mk(0, 0,0,32'h1000, 1,1,32'h2000, 0,0,0, 1,1,32'h2000, 1,0,0, 0,0,0));
    vecs.push_back(mk(0, 0,0,32'h1000, 0,0,32'h2000, 0,0,0, 0,0,32'h2000, 1,0,0, 0,0,0));
    vecs.push_back(mk(0, 0,0,0,        0,0,0, 1,0,32'hDEAD, 0,0,0,        1,0,0, 1,0,0));
    // round-robin: grants 0,1,0,1 with handoffs between them
    vecs.push_back(mk(0, 1,0,32'h1000, 1,0,32'h2000, 0,0,0, 0,0,0,        1,0,0, 1,0,0));
    vecs.push_back(mk(0, 1,0,32'h1000, 1,0,32'h2000, 0,0,0, 1,0,32'h1000, 0,0,0, 1,0,0));
    vecs.push_back(mk(0, 0,0,32'h1000, 1,0,32'h2000, 0,0,0, 0,0,32'h1000, 0,0,0, 1,0,0));
    vecs.push_back(mk(0, 1,0,32'h1000, 1,0,32'h2000, 0,0,0, 1,0,32'h2000, 1,0,0, 0,0,0));
    vecs.push_back(mk(0, 1,0,32'h1000, 0,0,32'h2000, 0,0,0, 0,0,32'h2000, 1,0,0, 0,0,0));
    vecs.push_back(mk(0, 1,0,32'h1000, 1,0,32'h2000, 0,0,0, 1,0,32'h1000, 0,0,0, 1,0,0));
    vecs.push_back(mk(0, 0,0,32'h1000, 1,0,32'h2000, 0,0,0, 0,0,32'h1000, 0,0,0, 1,0,0));
    vecs.push_back(mk(0, 1,0,32'h1000, 1,0,32'h2000, 0,0,0, 1,0,32'h2000, 1,0,0, 0,0,0));
    vecs.push_back(mk(0, 0,0,32'h1000, 0,0,32'h2000, 0,0,0, 0,0,32'h2000, 1,0,0, 0,0,0));
    vecs.push_back(mk(0, 0,0,0,        0,0,0,        0,0,0, 0,0,0,        1,0,0, 1,0,0));
    // outstanding cap of 2, one ack frees exactly one slot
    vecs.push_back(mk(1, 1,1,32'h3000, 0,0,0, 0,0,0,      0,0,0,        1,0,0,      1,0,0));
    vecs.push_back(mk(0, 1,1,32'h3000, 0,0,0, 0,0,0,      1,1,32'h3000, 0,0,0,      1,0,0));
    vecs.push_back(mk(0, 1,1,32'h3000, 0,0,0, 0,0,0,      1,1,32'h3000, 0,0,0,      1,0,0));
    vecs.push_back(mk(0, 1,1,32'h3000, 0,0,0, 0,0,0,      1,0,32'h3000, 1,0,0,      1,0,0));
    vecs.push_back(mk(0, 1,1,32'h3000, 0,0,0, 1,0,32'h55, 1,0,32'h3000, 1,1,32'h55, 1,0,0));
    vecs.push_back(mk(0, 1,1,32'h3000, 0,0,0, 0,0,0,      1,1,32'h3000, 0,0,0,      1,0,0));
    vecs.push_back(mk(0, 1,1,32'h3000, 0,0,0, 0,0,0,      1,0,32'h3000, 1,0,0,      1,0,0));
    vecs.push_back(mk(0, 0,0,0,        0,0,0, 0,0,0,      0,0,0,        1,0,0,      1,0,0));
    // slave stall for 3 cycles, then one accept and its ack
    vecs.push_back(mk(0, 1,1,32'h4000, 0,0,0, 0,1,0,      0,0,0,        1,0,0,      1,0,0));
    vecs.push_back(mk(0, 1,1,32'h4000, 0,0,0, 0,1,0,      1,1,32'h4000, 1,0,0,      1,0,0));
    vecs.push_back(mk(0, 1,1,32'h4000, 0,0,0, 0,1,0,      1,1,32'h4000, 1,0,0,      1,0,0));
    vecs.push_back(mk(0, 1,1,32'h4000, 0,0,0, 0,1,0,      1,1,32'h4000, 1,0,0,      1,0,0));
    vecs.push_back(mk(0, 1,1,32'h4000, 0,0,0, 0,0,0,      1,1,32'h4000, 0,0,0,      1,0,0));
    vecs.push_back(mk(0, 1,0,32'h4000, 0,0,0, 1,0,32'h77, 1,0,32'h4000, 0,1,32'h77, 1,0,0));
    vecs.push_back(mk(0, 0,0,0,        0,0,0, 0,0,0,      0,0,0,        0,0,0,      1,0,0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t v;
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    // reset state while reset is held
    chk("rst wb_cyc",   32'(wb_cyc_o),   0);
    chk("rst wb_stb",   32'(wb_stb_o),   0);
    chk("rst wb_adr",   wb_adr_o,        0);
    chk("rst m0_stall", 32'(m0_stall_o), 1);
    chk("rst m1_stall", 32'(m1_stall_o), 1);
    chk("rst m0_ack",   32'(m0_ack_o),   0);
    @(negedge clk);
    rst = 1'b0;

    // directed table
    fill_table();
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst_before) do_reset();
      m_cyc[0] = v.c0; m_stb[0] = v.s0; m_adr[0] = v.a0;
      m_cyc[1] = v.c1; m_stb[1] = v.s1; m_adr[1] = v.a1;
      wb_ack = v.ack; wb_stall = v.stall; wb_rdat = v.rdat;
      cycle(1'b0);
      chk($sformatf("vec%0d wb_cyc", i),   32'(got_cyc),      32'(v.e_cyc));
      chk($sformatf("vec%0d wb_stb", i),   32'(got_stb),      32'(v.e_stb));
      chk($sformatf("vec%0d wb_adr", i),   got_adr,           v.e_adr);
      chk($sformatf("vec%0d m0_stall", i), 32'(got_stall[0]), 32'(v.e_s0));
      chk($sformatf("vec%0d m0_ack", i),   32'(got_ack[0]),   32'(v.e_a0));
      chk($sformatf("vec%0d m0_dat", i),   got_dat[0],        v.e_d0);
      chk($sformatf("vec%0d m1_stall", i), 32'(got_stall[1]), 32'(v.e_s1));
      chk($sformatf("vec%0d m1_ack", i),   32'(got_ack[1]),   32'(v.e_a1));
      chk($sformatf("vec%0d m1_dat", i),   got_dat[1],        v.e_d1);
    end

    // async reset in the middle of a master 1 tenure with one transfer in flight
    clear_inputs();
    do_reset();
    m_cyc[1] = 1; m_stb[1] = 1; m_adr[1] = 32'h5000;
    cycle(1'b0);
    cycle(1'b0);
    chk("ares pre wb_cyc", 32'(got_cyc), 1);
    chk("ares pre wb_stb", 32'(got_stb), 1);
    m_stb[1] = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("ares wb_cyc",   32'(wb_cyc_o),   0);
    chk("ares m1_stall", 32'(m1_stall_o), 1);
    chk("ares wb_adr",   wb_adr_o,        0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    m_cyc[1] = 0;
    cycle(1'b0);
    m_cyc[0] = 1; m_adr[0] = 32'h6000;
    m_cyc[1] = 1; m_adr[1] = 32'h7000;
    cycle(1'b0);
    chk("ares tie idle m0_stall", 32'(got_stall[0]), 1);
    cycle(1'b0);
    chk("ares tie wb_adr",   got_adr,           32'h6000);
    chk("ares tie m0_stall", 32'(got_stall[0]), 0);
    chk("ares tie m1_stall", 32'(got_stall[1]), 1);

    // randomized traffic against the reference model
    clear_inputs();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (m_cyc[k]) begin
          if ($urandom_range(0, 7) == 0) m_cyc[k] = 0;
        end else begin
          if ($urandom_range(0, 2) == 0) m_cyc[k] = 1;
        end
        m_stb[k]  = m_cyc[k] ? 1'($urandom_range(0, 1)) : 1'b0;
        m_adr[k]  = $urandom;
        m_wdat[k] = $urandom;
        m_we[k]   = 1'($urandom_range(0, 1));
        m_sel[k]  = 4'($urandom_range(0, 15));
      end
      wb_ack   = ($urandom_range(0, 2) == 0);
      wb_stall = ($urandom_range(0, 3) == 0);
      wb_rdat  = $urandom;
      cycle(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
